// File: rtl/ext_gpio_pkg.sv
// Shared constants for the GPIO input filter: register offsets, the default
// register window base and the register selector used by the bus decode.
package ext_gpio_pkg;

  localparam logic [31:0] GPIO_FLT_BASE_ADDR = 32'hf000_0010;

  localparam logic [7:0] GPIO_FLT_STATUS = 8'h00;
  localparam logic [7:0] GPIO_FLT_RISE   = 8'h04;
  localparam logic [7:0] GPIO_FLT_FALL   = 8'h08;
  localparam logic [7:0] GPIO_FLT_PEND   = 8'h0c;
  localparam logic [7:0] GPIO_FLT_DEB    = 8'h10;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_RISE,
    REG_FALL,
    REG_PEND,
    REG_DEB
  } reg_sel_e;

endpackage

// File: rtl/ext_gpio_debounce_bit.sv
// One debounced GPIO bit: accepts a change of the synchronised input only after
// STABLE_TICKS consecutive sample ticks that all disagree with the clean value.
module ext_gpio_debounce_bit #(
  parameter int STABLE_TICKS = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic tick,
  input  logic bypass,
  input  logic clr_cnt,
  input  logic s2,
  output logic clean
);

  localparam int CNT_W = (STABLE_TICKS > 1) ? $clog2(STABLE_TICKS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

  logic [CNT_W-1:0] cnt;

  // Mismatch counter and clean flop; bypass follows s2 directly.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cnt   <= '0;
      clean <= 1'b0;
    end else if (bypass) begin
      clean <= s2;
      cnt   <= '0;
    end else if (clr_cnt) begin
      cnt <= '0;
    end else if (tick) begin
      if (s2 == clean) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        clean <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/ext_gpio_in_filter.sv
// GPIO pad input conditioner: 2-flop synchroniser, per-bit debounce against a
// programmable sample tick, rise/fall event latching and a small register bank.
module ext_gpio_in_filter
  import ext_gpio_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter int                    DATA_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = ADDR_WIDTH'(GPIO_FLT_BASE_ADDR),
  parameter int                    STABLE_TICKS = 3,
  parameter int                    DB_CNT_WIDTH = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst,
  input  logic                  op,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_w,
  output logic [DATA_WIDTH-1:0] data_r,
  input  logic [31:0]           pad_in,
  output logic [31:0]           gpio_in_clean,
  output logic                  irq
);

  logic [31:0]             s1, s2, clean, clean_d;
  logic [31:0]             rise_en, fall_en, pending;
  logic [DB_CNT_WIDTH-1:0] debounce, presc;
  logic [ADDR_WIDTH-1:0]   off;
  reg_sel_e                sel;
  logic                    wr, rd, deb_wr, bypass, tick;
  logic [31:0]             pend_clr, ev_set;
  logic [DATA_WIDTH-1:0]   readback;

  assign off      = addr - BASE_ADDR;
  assign wr       = op & rw;
  assign rd       = op & ~rw;
  assign deb_wr   = wr && (sel == REG_DEB);
  assign pend_clr = (wr && (sel == REG_PEND)) ? data_w[31:0] : 32'h0;
  assign bypass   = (debounce == '0);
  assign tick     = !bypass && (presc == debounce - DB_CNT_WIDTH'(1));
  assign ev_set   = (clean & ~clean_d & rise_en) | (~clean & clean_d & fall_en);

  // Address decode; misaligned offsets never match an exact register offset.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    sel = REG_NONE;
    case (off)
      ADDR_WIDTH'(GPIO_FLT_STATUS): sel = REG_STATUS;
      ADDR_WIDTH'(GPIO_FLT_RISE):   sel = REG_RISE;
      ADDR_WIDTH'(GPIO_FLT_FALL):   sel = REG_FALL;
      ADDR_WIDTH'(GPIO_FLT_PEND):   sel = REG_PEND;
      ADDR_WIDTH'(GPIO_FLT_DEB):    sel = REG_DEB;
      default:                      sel = REG_NONE;
    endcase
  end

  // Read mux for the register window.
  always_comb begin
    readback = '0;
    case (sel)
      REG_STATUS: readback = DATA_WIDTH'(clean);
      REG_RISE:   readback = DATA_WIDTH'(rise_en);
      REG_FALL:   readback = DATA_WIDTH'(fall_en);
      REG_PEND:   readback = DATA_WIDTH'(pending);
      REG_DEB:    readback = DATA_WIDTH'(debounce);
      default:    readback = '0;
    endcase
  end

  // Pad synchroniser and clean-value history for edge detection.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      s1      <= '0;
      s2      <= '0;
      clean_d <= '0;
    end else begin
      s1      <= pad_in;
      s2      <= s1;
      clean_d <= clean;
    end
  end

  // Sample-tick prescaler: counts 0..N-1, restarts on any DEBOUNCE write.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      presc <= '0;
    end else if (deb_wr || bypass || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + DB_CNT_WIDTH'(1);
    end
  end

  // Config registers, W1C pending (new events beat a same-cycle clear) and read data.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      rise_en  <= '0;
      fall_en  <= '0;
      debounce <= '0;
      pending  <= '0;
      data_r   <= '0;
    end else begin
      if (wr && (sel == REG_RISE)) rise_en <= data_w[31:0];
      if (wr && (sel == REG_FALL)) fall_en <= data_w[31:0];
      if (deb_wr)                  debounce <= data_w[DB_CNT_WIDTH-1:0];
      pending <= (pending & ~pend_clr) | ev_set;
      data_r  <= rd ? readback : '0;
    end
  end

  for (genvar i = 0; i < 32; i++) begin : g_bit
    ext_gpio_debounce_bit #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_bit (
      .sys_clk(sys_clk),
      .sys_rst(sys_rst),
      .tick   (tick),
      .bypass (bypass),
      .clr_cnt(deb_wr),
      .s2     (s2[i]),
      .clean  (clean[i])
    );
  end

  assign gpio_in_clean = clean;
  assign irq           = |pending;

endmodule

// File: tb/tb_ext_gpio_in_filter.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a behavioural model.
module tb_ext_gpio_in_filter;

  localparam logic [31:0] BASE   = 32'hf000_0010;
  localparam int          STABLE = 3;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b0;
  logic        op = 1'b0, rw = 1'b0;
  logic [31:0] addr = '0, data_w = '0, pad_in = '0;
  logic [31:0] data_r, gpio_in_clean;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;
  bit compare_en = 1'b0;

  ext_gpio_in_filter dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .op           (op),
    .rw           (rw),
    .addr         (addr),
    .data_w       (data_w),
    .data_r       (data_r),
    .pad_in       (pad_in),
    .gpio_in_clean(gpio_in_clean),
    .irq          (irq)
  );

  initial forever #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_s1, m_s2, m_clean, m_clean_d, m_rise, m_fall, m_pend, m_data_r;
  int unsigned m_deb, m_since;
  int          m_run [32];
  longint      t_off;
  bit          t_hit, t_wr, t_debwr, t_tick;
  int          t_idx;
  logic [31:0] t_rd, t_clean, t_set, t_clr;

  always @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_clean_d = '0;
      m_rise = '0; m_fall = '0; m_pend = '0; m_data_r = '0;
      m_deb = 0; m_since = 0;
      foreach (m_run[i]) m_run[i] = 0;
    end else begin
      t_off = longint'(addr) - longint'(BASE);
      t_hit = (t_off >= 0) && (t_off < 20) && (t_off % 4 == 0);
      t_idx = t_hit ? int'(t_off / 4) : -1;
      case (t_idx)
        0:       t_rd = m_clean;
        1:       t_rd = m_rise;
        2:       t_rd = m_fall;
        3:       t_rd = m_pend;
        4:       t_rd = m_deb;
        default: t_rd = '0;
      endcase
      t_wr    = op && rw && t_hit;
      t_debwr = t_wr && (t_idx == 4);
      t_tick  = (m_deb != 0) && ((m_since % m_deb) == m_deb - 1);
      t_clean = m_clean;
      if (m_deb == 0) t_clean = m_s2;
      else if (!t_debwr && t_tick) begin
        for (int i = 0; i < 32; i++) begin
          if (m_s2[i] == m_clean[i]) m_run[i] = 0;
          else if (m_run[i] + 1 == STABLE) begin
            t_clean[i] = m_s2[i];
            m_run[i]   = 0;
          end else m_run[i]++;
        end
      end
      if (t_debwr) foreach (m_run[i]) m_run[i] = 0;
      t_set    = (m_clean & ~m_clean_d & m_rise) | (~m_clean & m_clean_d & m_fall);
      t_clr    = (t_wr && t_idx == 3) ? data_w : '0;
      m_pend   = (m_pend & ~t_clr) | t_set;
      m_data_r = (op && !rw) ? t_rd : '0;
      if (t_wr && t_idx == 1) m_rise = data_w;
      if (t_wr && t_idx == 2) m_fall = data_w;
      if (t_debwr) m_deb = data_w[15:0];
      m_since   = t_debwr ? 0 : m_since + 1;
      m_clean_d = m_clean;
      m_clean   = t_clean;
      m_s2      = m_s1;
      m_s1      = pad_in;
    end
  end

  // Cycle-by-cycle comparison, away from the active edge.
  always @(negedge sys_clk) begin
    if (compare_en) begin
      check("model_data_r", data_r, m_data_r);
      check("model_clean", gpio_in_clean, m_clean);
      check("model_irq", {31'b0, irq}, {31'b0, |m_pend});
    end
  end

  // ---------------- bus helpers (called at posedge+1) ----------------
  task automatic tick_n(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    op = 1'b1; rw = 1'b1; addr = a; data_w = d;
    tick_n(1);
    op = 1'b0; rw = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    op = 1'b1; rw = 1'b0; addr = a;
    tick_n(1);
    d  = data_r;
    op = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 7))
      5:       return BASE + 32'h14;
      6:       return BASE + 4 * $urandom_range(0, 4) + $urandom_range(1, 3);
      7:       return $urandom;
      default: return BASE + 4 * $urandom_range(0, 4);
    endcase
  endfunction

  logic [31:0] rdv;
  int          waited;

  initial begin
    #2 sys_rst = 1'b1;
    compare_en = 1'b1;
    tick_n(3);
    sys_rst = 1'b0;

    // Registers all read zero out of reset.
    for (int r = 0; r < 5; r++) begin
      bus_read(BASE + 4 * r, rdv);
      check("reset_reg", rdv, 32'h0);
    end

    // Bypass latency: visible after the third edge, not the second.
    pad_in = 32'ha1b2c3d4;
    tick_n(2);
    check("bypass_edge2", gpio_in_clean, 32'h0);
    tick_n(1);
    check("bypass_edge3", gpio_in_clean, 32'ha1b2c3d4);
    bus_read(BASE, rdv);
    check("status_read", rdv, 32'ha1b2c3d4);
    pad_in = '0;
    tick_n(4);

    // Debounce N=4: short pulse rejected, long level accepted and released.
    bus_write(BASE + 32'h10, 32'd4);
    tick_n(8);
    pad_in[0] = 1'b1;
    tick_n(5);
    pad_in[0] = 1'b0;
    tick_n(20);
    check("deb_pulse_reject", {31'b0, gpio_in_clean[0]}, 32'h0);
    pad_in[0] = 1'b1;
    waited = 0;
    while (waited < 15 && !gpio_in_clean[0]) begin
      tick_n(1);
      waited++;
    end
    check("deb_accept_rise", {31'b0, gpio_in_clean[0]}, 32'h1);
    tick_n(20 - waited);
    pad_in[0] = 1'b0;
    tick_n(20);
    check("deb_accept_fall", {31'b0, gpio_in_clean[0]}, 32'h0);
    bus_write(BASE + 32'h10, 32'd0);
    tick_n(2);

    // Rise event on bit 5, then W1C clear.
    bus_write(BASE + 32'h04, 32'h20);
    pad_in[5] = 1'b1;
    tick_n(5);
    bus_read(BASE + 32'h0c, rdv);
    check("rise_pending", rdv, 32'h20);
    check("rise_irq", {31'b0, irq}, 32'h1);
    bus_write(BASE + 32'h0c, 32'h20);
    bus_read(BASE + 32'h0c, rdv);
    check("w1c_pending", rdv, 32'h0);
    check("w1c_irq", {31'b0, irq}, 32'h0);
    pad_in[5] = 1'b0;
    tick_n(4);

    // Collision: fall event lands on the same edge as a clear of that bit.
    pad_in[0] = 1'b1;
    tick_n(5);
    bus_write(BASE + 32'h08, 32'h1);
    pad_in[0] = 1'b0;
    tick_n(3);
    bus_write(BASE + 32'h0c, 32'h1);
    bus_read(BASE + 32'h0c, rdv);
    check("collision_set_wins", rdv, 32'h1);
    bus_write(BASE + 32'h0c, 32'h1);
    bus_read(BASE + 32'h0c, rdv);
    check("collision_cleared", rdv, 32'h0);

    // Decode: out-of-window and misaligned accesses.
    bus_read(BASE + 32'h14, rdv);
    check("miss_read", rdv, 32'h0);
    bus_read(BASE + 32'h02, rdv);
    check("misaligned_read", rdv, 32'h0);
    bus_write(BASE + 32'h14, 32'hffff_ffff);
    bus_write(BASE + 32'h02, 32'hffff_ffff);
    bus_write(BASE + 32'h06, 32'hffff_ffff);
    bus_read(BASE + 32'h04, rdv);
    check("miss_rise_kept", rdv, 32'h20);
    bus_read(BASE + 32'h08, rdv);
    check("miss_fall_kept", rdv, 32'h1);
    bus_read(BASE + 32'h10, rdv);
    check("miss_deb_kept", rdv, 32'h0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      op     = ($urandom_range(0, 2) == 0);
      rw     = $urandom_range(0, 1);
      addr   = rand_addr();
      data_w = (addr == BASE + 32'h10) ? $urandom_range(0, 5) : $urandom;
      if ($urandom_range(0, 7) == 0) pad_in = pad_in ^ ($urandom & $urandom & $urandom);
      tick_n(1);
    end
    op = 1'b0; rw = 1'b0;
    bus_write(BASE + 32'h04, 32'hffff_ffff);
    pad_in = 32'h0;
    tick_n(30);
    pad_in = 32'hffff_ffff;
    tick_n(30);

    // Mid-run asynchronous reset: outputs clear with no clock edge.
    pad_in  = 32'h0;
    sys_rst = 1'b1;
    #1;
    check("rst_data_r", data_r, 32'h0);
    check("rst_clean", gpio_in_clean, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    #1;
    tick_n(2);
    sys_rst = 1'b0;
    for (int r = 0; r < 5; r++) begin
      bus_read(BASE + 4 * r, rdv);
      check("midrun_reset_reg", rdv, 32'h0);
    end
    tick_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
